// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle MIPS control FSM:
//   - field widths (OP_W opcode/funct width, ST_W state register width)
//   - state encoding (state_t)
//   - opcode constants for the supported instruction subset
//   - ALU_OP / ALU_SRC_B / PC_SOURCE select encodings
//   - ctrl_word_t: the full set of datapath controls produced each cycle
// Optional feature macro used by the importing RTL: MULTICYCLE_ILLEGAL_TRAP_EN
// ---------------------------------------------------------------------------
package ctrl_pkg;

  localparam int OP_W = 6;
  localparam int ST_W = 4;

  // Encodings 4'd14 and 4'd15 are unused and recover to FETCH.
  typedef enum logic [ST_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWR    = 4'd4,
    MEMWB    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    ADDI_EX  = 4'd8,
    ORI_EX   = 4'd9,
    ITYPE_WB = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    TRAP     = 4'd13
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_word_t;

  // All enables low, all selects zero.
  localparam ctrl_word_t CTRL_IDLE = ctrl_word_t'(16'h0000);

endpackage

// File: rtl/ctrl_out_decode.sv
// ---------------------------------------------------------------------------
// ctrl_out_decode
// Purely combinational state -> control-word decode for multicycle_ctrl.
// Ports:
//   i_state   : current FSM state
//   i_mem_ack : memory handshake; only used in FETCH (IR/PC load on ack)
//   o_ctrl    : full datapath control word for this cycle
// States with no listed controls (TRAP, unused encodings) drive CTRL_IDLE.
// ---------------------------------------------------------------------------
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_mem_ack,
  output ctrl_word_t o_ctrl
);

  // Moore decode of the control word; FETCH also qualifies IR/PC loads with ack.
  always_comb begin
    o_ctrl = CTRL_IDLE;
    case (i_state)
      FETCH: begin
        o_ctrl.mem_req   = 1'b1;
        o_ctrl.ior_d     = 1'b0;
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        // PC+4 and the instruction word are captured only when memory delivers.
        o_ctrl.ir_write  = i_mem_ack;
        o_ctrl.pc_write  = i_mem_ack;
      end
      DECODE: begin
        // Branch target precompute: PC + (imm << 2) into ALUOut.
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      MEMRD: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.ior_d   = 1'b1;
      end
      MEMWR: begin
        o_ctrl.mem_req   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.ior_d     = 1'b1;
      end
      MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_dst    = 1'b0;
      end
      RTYPE_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      RTYPE_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.mem_to_reg = 1'b0;
      end
      ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ORI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_OR;
      end
      ITYPE_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b0;
        o_ctrl.mem_to_reg = 1'b0;
      end
      BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      TRAP: begin
        o_ctrl = CTRL_IDLE;
      end
      default: begin
        o_ctrl = CTRL_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Moore FSM sequencing a shared-resource multicycle MIPS datapath (one ALU,
// one unified memory port). Holds the state register and next-state logic;
// control-word decode lives in ctrl_out_decode.
// Ports:
//   CLK, RST_N     : clock, synchronous active-low reset
//   OP, FUNCT      : opcode / funct from IR (FUNCT is for the ALU decoder)
//   ZERO           : ALU zero flag (consumed by the datapath PC logic)
//   MEM_ACK        : memory done for the current request
//   MEM_REQ..PC_SOURCE : datapath enables and mux selects
//   ILLEGAL        : sticky illegal-opcode flag
// Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN
//   defined   -> illegal opcode parks the FSM in TRAP with ILLEGAL=1
//   undefined -> illegal opcode is a NOP, ILLEGAL tied low
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [OP_W-1:0] OP,
  input  logic [OP_W-1:0] FUNCT,
  input  logic            ZERO,
  input  logic            MEM_ACK,
  output logic            MEM_REQ,
  output logic            PC_WRITE,
  output logic            PC_WRITE_COND,
  output logic            IOR_D,
  output logic            MEM_WRITE,
  output logic            IR_WRITE,
  output logic            MEM_TO_REG,
  output logic            REG_DST,
  output logic            REG_WRITE,
  output logic            ALU_SRC_A,
  output logic [1:0]      ALU_SRC_B,
  output logic [1:0]      ALU_OP,
  output logic [1:0]      PC_SOURCE,
  output logic            ILLEGAL
);

  state_t     r_state;
  state_t     w_next_state;
  ctrl_word_t w_ctrl_dec;
  ctrl_word_t w_ctrl;

  // FUNCT and ZERO are routed here for the datapath; the FSM itself ignores them.
  logic w_unused_inputs;
  assign w_unused_inputs = ^{FUNCT, ZERO};

  // State register; reset restarts at FETCH and abandons any open request.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; memory states hold until MEM_ACK.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH: begin
        if (MEM_ACK) begin
          w_next_state = DECODE;
        end else begin
          w_next_state = FETCH;
        end
      end
      DECODE: begin
        case (OP)
          OP_LW, OP_SW: w_next_state = MEMADR;
          OP_RTYPE:     w_next_state = RTYPE_EX;
          OP_BEQ:       w_next_state = BRANCH;
          OP_J:         w_next_state = JUMP;
          OP_ADDI:      w_next_state = ADDI_EX;
          OP_ORI:       w_next_state = ORI_EX;
          default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            w_next_state = TRAP;
`else
            w_next_state = FETCH;
`endif
          end
        endcase
      end
      MEMADR: begin
        if (OP == OP_LW) begin
          w_next_state = MEMRD;
        end else begin
          w_next_state = MEMWR;
        end
      end
      MEMRD: begin
        if (MEM_ACK) begin
          w_next_state = MEMWB;
        end else begin
          w_next_state = MEMRD;
        end
      end
      MEMWR: begin
        if (MEM_ACK) begin
          w_next_state = FETCH;
        end else begin
          w_next_state = MEMWR;
        end
      end
      MEMWB:    w_next_state = FETCH;
      RTYPE_EX: w_next_state = RTYPE_WB;
      RTYPE_WB: w_next_state = FETCH;
      ADDI_EX:  w_next_state = ITYPE_WB;
      ORI_EX:   w_next_state = ITYPE_WB;
      ITYPE_WB: w_next_state = FETCH;
      BRANCH:   w_next_state = FETCH;
      JUMP:     w_next_state = FETCH;
      TRAP: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        w_next_state = TRAP;
`else
        w_next_state = FETCH;
`endif
      end
      default:  w_next_state = FETCH;
    endcase
  end

  ctrl_out_decode u_out_decode (
    .i_state   (r_state),
    .i_mem_ack (MEM_ACK),
    .o_ctrl    (w_ctrl_dec)
  );

  // While reset is held every enable and select is forced low, even before
  // the first reset edge has initialised the state register.
  always_comb begin
    if (!RST_N) begin
      w_ctrl = CTRL_IDLE;
    end else begin
      w_ctrl = w_ctrl_dec;
    end
  end

  assign MEM_REQ       = w_ctrl.mem_req;
  assign PC_WRITE      = w_ctrl.pc_write;
  assign PC_WRITE_COND = w_ctrl.pc_write_cond;
  assign IOR_D         = w_ctrl.ior_d;
  assign MEM_WRITE     = w_ctrl.mem_write;
  assign IR_WRITE      = w_ctrl.ir_write;
  assign MEM_TO_REG    = w_ctrl.mem_to_reg;
  assign REG_DST       = w_ctrl.reg_dst;
  assign REG_WRITE     = w_ctrl.reg_write;
  assign ALU_SRC_A     = w_ctrl.alu_src_a;
  assign ALU_SRC_B     = w_ctrl.alu_src_b;
  assign ALU_OP        = w_ctrl.alu_op;
  assign PC_SOURCE     = w_ctrl.pc_source;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic r_illegal;

  // Sticky flag: set on the transition into TRAP, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= r_illegal | (w_next_state == TRAP);
    end
  end

  assign ILLEGAL = r_illegal;
`else
  assign ILLEGAL = 1'b0;
`endif

endmodule
